// File: rtl/shift_pkg.sv
// Shared encodings for the sequential shifter: op codes, FSM states, STEP legality.
// Rotate support is enabled with the SHIFT_ROTATE_EN macro (see shift_step).
package shift_pkg;

    typedef enum logic [1:0] {
        OP_SRL = 2'b00,
        OP_SRA = 2'b01,
        OP_SLL = 2'b10,
        OP_ROR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_e;

    localparam int MAX_STEP = 8;

    function automatic bit step_is_legal(input int s);
        return (s == 1) || (s == 2) || (s == 4) || (s == 8);
    endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-iteration shifter: moves acc by k (0..STEP) bits per op.
// Macro SHIFT_ROTATE_EN: when defined, op 11 rotates right; otherwise it behaves as SRL.
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 1,
    parameter int KW    = $clog2(STEP + 1)
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [1:0]       op,
    input  logic [KW-1:0]    k,
    output logic [WIDTH-1:0] acc_next
);

`ifdef SHIFT_ROTATE_EN
    logic [2*WIDTH-1:0] rot;
    assign rot = {acc, acc} >> k;
`endif

    always_comb begin
        acc_next = acc >> k;
        case (op)
            OP_SRL: acc_next = acc >> k;
            // Arithmetic shift replicates the current MSB, so sign survives every iteration.
            OP_SRA: acc_next = $signed(acc) >>> k;
            OP_SLL: acc_next = acc << k;
`ifdef SHIFT_ROTATE_EN
            OP_ROR: acc_next = rot[WIDTH-1:0];
`endif
            default: acc_next = acc >> k;
        endcase
    end

endmodule

// File: rtl/seq_shift_unit.sv
// Multi-cycle shifter: FSM, remaining-amount counter and result register around shift_step.
// Macro SHIFT_ROTATE_EN enables op 11 as rotate right (handled inside shift_step).
module seq_shift_unit
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [1:0]               op,
    input  logic [WIDTH-1:0]         data_in,
    input  logic [$clog2(WIDTH)-1:0] shamt,
    output logic                     busy,
    output logic                     done,
    output logic [WIDTH-1:0]         result
);

    localparam int SHW = $clog2(WIDTH);
    localparam int KW  = $clog2(STEP + 1);

    if (!step_is_legal(STEP) || ((WIDTH & (WIDTH - 1)) != 0)) begin : g_bad_param
        $error("seq_shift_unit: STEP must be 1,2,4,8 and WIDTH a power of two");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc, acc_step;
    logic [SHW-1:0]   rem, rem_next;
    logic [1:0]       op_q;
    logic [KW-1:0]    k;
    logic             accept;

    // Start is only honoured in IDLE or DONE; mid-shift requests are dropped.
    assign accept = start && ((state_q == IDLE) || (state_q == DONE));
    assign busy   = (state_q == SHIFT);
    assign done   = (state_q == DONE);

    always_comb begin
        k = KW'(STEP);
        if (int'(rem) < STEP) k = KW'(rem);
    end

    assign rem_next = rem - SHW'(k);

    shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP),
        .KW    (KW)
    ) u_step (
        .acc      (acc),
        .op       (op_q),
        .k        (k),
        .acc_next (acc_step)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) state_d = (shamt == '0) ? DONE : SHIFT;
                else       state_d = IDLE;
            end
            SHIFT: begin
                if (rem_next == '0) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc     <= '0;
            rem     <= '0;
            op_q    <= '0;
            result  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                acc  <= data_in;
                rem  <= shamt;
                op_q <= op;
                // A zero-amount request enters DONE directly, so the operand is the result.
                if (shamt == '0) result <= data_in;
            end else if (state_q == SHIFT) begin
                acc <= acc_step;
                rem <= rem_next;
                if (rem_next == '0) result <= acc_step;
            end
        end
    end

endmodule
